// File: rtl/mul_arb.sv
// Two-producer round-robin front end for a single 8x8 unsigned multiplier,
// with four-phase handshakes on both the input side and the output side.
module mul_arb #(
  parameter int unsigned MUL_WAIT = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        rfd_a,
  input  logic        dav_a_,
  input  logic [7:0]  xa,
  input  logic [7:0]  ya,
  output logic        rfd_b,
  input  logic        dav_b_,
  input  logic [7:0]  xb,
  input  logic [7:0]  yb,
  output logic [15:0] m,
  output logic        src,
  output logic        dav_out_,
  input  logic        rfd_out
);

  typedef enum logic [2:0] {IDLE, IN_ACK, SETTLE, OUT_REQ, OUT_ACK} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MUL_WAIT);

  state_t      state_q, state_d;
  logic        rfd_a_q, rfd_a_d;
  logic        rfd_b_q, rfd_b_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] m_q, m_d;
  logic        src_q, src_d;
  logic        dav_out_q, dav_out_d;

  logic        pend_a, pend_b, grant_b, sel_dav;
  logic [15:0] product;

  assign pend_a  = ~dav_a_;
  assign pend_b  = ~dav_b_;
  // B wins when alone, or when both pend and A was served last.
  assign grant_b = pend_b & (~pend_a | ~last_q);
  assign sel_dav = sel_q ? dav_b_ : dav_a_;
  assign product = {8'h00, x_q} * {8'h00, y_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rfd_a_q   <= 1'b1;
      rfd_b_q   <= 1'b1;
      x_q       <= '0;
      y_q       <= '0;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      m_q       <= '0;
      src_q     <= 1'b0;
      dav_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rfd_a_q   <= rfd_a_d;
      rfd_b_q   <= rfd_b_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      src_q     <= src_d;
      dav_out_q <= dav_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend_a || pend_b) state_d = IN_ACK;
      IN_ACK:  if (sel_dav)          state_d = SETTLE;
      SETTLE:  if (cnt_q <= 4'd1)    state_d = OUT_REQ;
      OUT_REQ: if (rfd_out)          state_d = OUT_ACK;
      OUT_ACK: if (!rfd_out)         state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    rfd_a_d   = rfd_a_q;
    rfd_b_d   = rfd_b_q;
    x_d       = x_q;
    y_d       = y_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    src_d     = src_q;
    dav_out_d = dav_out_q;
    case (state_q)
      IDLE: begin
        if (pend_a || pend_b) begin
          sel_d  = grant_b;
          last_d = grant_b;
          x_d    = grant_b ? xb : xa;
          y_d    = grant_b ? yb : ya;
          if (grant_b) rfd_b_d = 1'b0;
          else         rfd_a_d = 1'b0;
        end
      end
      IN_ACK: begin
        if (sel_dav) begin
          if (sel_q) rfd_b_d = 1'b1;
          else       rfd_a_d = 1'b1;
          cnt_d = WAIT_INIT;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
      end
      OUT_REQ: begin
        if (rfd_out) begin
          m_d       = product;
          src_d     = sel_q;
          dav_out_d = 1'b0;
        end
      end
      OUT_ACK: begin
        if (!rfd_out) dav_out_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign rfd_a    = rfd_a_q;
  assign rfd_b    = rfd_b_q;
  assign m        = m_q;
  assign src      = src_q;
  assign dav_out_ = dav_out_q;

endmodule
